// File: rtl/oci_dct_pkg.sv
// Shared widths, FSM states and DCT code constants for the OCI trace packer.
package oci_dct_pkg;

  localparam int ENTRY_W     = 2;
  localparam int MAX_ENTRIES = 15;
  localparam int BUF_W       = ENTRY_W * MAX_ENTRIES;
  localparam int CNT_W       = 4;
  localparam int DROP_W      = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_e;

  localparam logic [ENTRY_W-1:0] DCT_NT  = 2'b01;
  localparam logic [ENTRY_W-1:0] DCT_TK  = 2'b10;
  localparam logic [ENTRY_W-1:0] DCT_EXC = 2'b11;

  // Position a code at accumulator slot 'slot' (entry k occupies bits [2k+1:2k]).
  function automatic logic [BUF_W-1:0] place_code(input logic [ENTRY_W-1:0] code,
                                                  input logic [CNT_W-1:0]   slot);
    return BUF_W'(code) << (ENTRY_W * int'(slot));
  endfunction

endpackage

// File: rtl/oci_dct_frame_reg.sv
// Single-entry valid/ready holding register for packed DCT frames.
// Handshake: a frame leaves when valid & ready are both high at a clock edge;
// data/count are stable while valid & ~ready; a load may coincide with the
// handshake, in which case valid stays high with the new frame.
module oci_dct_frame_reg
  import oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             ready,
  output logic             valid,
  output logic [BUF_W-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Load a new frame or retire the current one on handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/final_project_soc_nios2_qsys_0_oci_dct_packer.sv
// DCT packer: collects 2-bit branch codes into a 15-entry accumulator, hands
// full or flushed accumulators to a frame register, and sequences the
// end-of-test drain.
module final_project_soc_nios2_qsys_0_oci_dct_packer
  import oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trace_enable,
  input  logic               dct_in_valid,
  input  logic [ENTRY_W-1:0] dct_in_code,
  input  logic               flush_req,
  output logic               frame_valid,
  output logic [BUF_W-1:0]   frame_data,
  output logic [CNT_W-1:0]   frame_count,
  input  logic               frame_ready,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  input  logic               test_ending,
  output logic               test_has_ended,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  input  logic               overflow_clr
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_ENTRIES);

  dct_state_e state;
  logic       flush_pend;
  logic       accept;
  logic       acc_full;
  logic       acc_empty;
  logic       slot_free;
  logic       transfer;
  logic       drop;
  logic       flush_set;
  logic       flush_clr;

  assign accept    = dct_in_valid && trace_enable && (state == ST_RUN);
  assign acc_full  = (dct_count == FULL_CNT);
  assign acc_empty = (dct_count == '0);
  assign slot_free = !frame_valid || frame_ready;
  assign transfer  = slot_free && (acc_full || (flush_pend && !acc_empty));
  assign drop      = accept && acc_full && !transfer;

  // A flush started in the same cycle as a code write must still see that
  // code, so an empty accumulator only retires the flush when nothing is
  // being written.
  assign flush_set = flush_req || ((state == ST_RUN) && test_ending);
  assign flush_clr = transfer || (acc_empty && !accept);

  // Accumulator: transfer empties it (keeping a same-cycle code in slot 0);
  // otherwise accepted codes append until full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (transfer) begin
      dct_buffer <= accept ? place_code(dct_in_code, '0) : '0;
      dct_count  <= accept ? CNT_W'(1) : '0;
    end else if (accept && !acc_full) begin
      dct_buffer <= dct_buffer | place_code(dct_in_code, dct_count);
      dct_count  <= dct_count + CNT_W'(1);
    end
  end

  // Pending flush request, held until the accumulator has been handed off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush_set || (flush_pend && !flush_clr);
    end
  end

  // Sticky overflow flag and saturating drop counter; clear wins over a drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

  // Run/drain/done sequencing with registered end-of-test flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_RUN;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (test_ending) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (acc_empty && !frame_valid) begin
            state          <= ST_DONE;
            test_has_ended <= 1'b1;
          end
        end
        ST_DONE: begin
          test_has_ended <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  oci_dct_frame_reg u_frame_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (transfer),
    .load_data  (dct_buffer),
    .load_count (dct_count),
    .ready      (frame_ready),
    .valid      (frame_valid),
    .data       (frame_data),
    .count      (frame_count)
  );

endmodule
